// File: rtl/bandai_unlock_host.sv
// bandai_unlock_host
//   Console-side initiator for the Bandai 2003 cartridge unlock handshake.
//   Pulses the cartridge reset, drives the unlock address pair 5Ah / A5h on
//   the cartridge ADDR bus, then receives the 18-bit serial frame returned on
//   SI (start bit 0, 16 payload bits LSB first, stop bit 0) and checks the
//   payload against EXP_WORD. A good frame sets the sticky CTRL1_B7 flag
//   (SYSTEM_CTRL1 bit 7) that enables cartridge access elsewhere in the ASIC.
//
//   Optional feature macro: BANDAI_RETRY_EN
//     defined   : a failed attempt is retried up to MAX_RETRY more times
//                 (each retry re-pulses CART_RSTn); DONE only on the last one.
//     undefined : single attempt per START, MAX_RETRY only range-checked.
//
// Ports
//   CLK        in   clock, shared with the cartridge
//   RSTn       in   asynchronous active-low reset
//   START      in   1-cycle pulse, starts a sequence; ignored unless idle
//   CART_RSTn  out  cartridge reset, active-low
//   ADDR[7:0]  out  cartridge address bus value
//   ADDR_OE    out  1 while this block drives ADDR
//   SI         in   cartridge SO, idle high
//   BUSY       out  1 from START accept until DONE
//   DONE       out  1-cycle pulse at end of the sequence
//   PASS       out  result of last sequence, valid from DONE
//   ERR[1:0]   out  00 ok, 01 timeout, 10 payload mismatch, 11 bad stop bit
//   RXDATA     out  last received payload
//   CTRL1_B7   out  sticky unlock flag, cleared only by RSTn
//
// State table
//   state  | meaning
//   IDLE   | waiting for START
//   CRST   | CART_RSTn held low for RST_CYC cycles
//   GAP    | one cycle with reset released and bus released
//   ACK    | ADDR = 5Ah driven
//   NAK    | ADDR = A5h driven; cartridge loads its frame on the closing edge
//   WAIT   | bus released, waiting up to TIMEOUT edges for the start bit
//   RX     | shifting 16 payload bits, LSB first
//   STOP   | stop bit check and payload compare
//   END    | DONE pulse (or retry in the retry build)

module bandai_unlock_host #(
    parameter int unsigned RST_CYC   = 8,
    parameter int unsigned TIMEOUT   = 64,
    parameter logic [15:0] EXP_WORD  = 16'h28A0,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        START,
    output logic        CART_RSTn,
    output logic [7:0]  ADDR,
    output logic        ADDR_OE,
    input  logic        SI,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [1:0]  ERR,
    output logic [15:0] RXDATA,
    output logic        CTRL1_B7
);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_PAYLOAD = 2'b10;
    localparam logic [1:0] ERR_STOP    = 2'b11;

    // One shared down-counter covers the reset pulse, the start-bit timeout
    // and the 16-bit receive count; size it for the largest of the three.
    localparam int unsigned T_MAX_A = (RST_CYC > TIMEOUT) ? RST_CYC : TIMEOUT;
    localparam int unsigned T_MAX   = (T_MAX_A > 16) ? T_MAX_A : 16;
    localparam int unsigned TW      = $clog2(T_MAX);

    // Parameter sanity: reset pulse needs at least one cycle, the timeout at
    // least two edges, and the retry count must fit a byte-wide counter.
    if (RST_CYC < 1 || TIMEOUT < 2 || MAX_RETRY > 255) begin : g_bad_param
        $error("bandai_unlock_host: illegal parameter value");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_CRST,
        S_GAP,
        S_ACK,
        S_NAK,
        S_WAIT,
        S_RX,
        S_STOP,
        S_END
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] tmr;
    logic          err_set;
    logic [1:0]    err_val;
    logic          retry_now;
    logic          start_acc;

    assign start_acc = (state == S_IDLE) && START;

    // ------------------------------------------------------------------
    // Retry control
    // ------------------------------------------------------------------
`ifdef BANDAI_RETRY_EN
    localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    logic [RW-1:0] retry_cnt;

    // ERR already holds this attempt's result by the time END is reached.
    assign retry_now = (state == S_END) && (ERR != ERR_OK) &&
                       (retry_cnt < RW'(MAX_RETRY));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            retry_cnt <= '0;
        end else if (start_acc) begin
            retry_cnt <= '0;
        end else if (retry_now) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end
`else
    assign retry_now = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        err_val   = ERR_OK;
        case (state)
            S_IDLE: begin
                if (START) begin
                    state_nxt = S_CRST;
                end
            end
            S_CRST: begin
                if (tmr == '0) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP:  state_nxt = S_ACK;
            S_ACK:  state_nxt = S_NAK;
            S_NAK:  state_nxt = S_WAIT;
            S_WAIT: begin
                // A start bit on the final timeout edge still counts.
                if (!SI) begin
                    state_nxt = S_RX;
                end else if (tmr == '0) begin
                    state_nxt = S_END;
                    err_set   = 1'b1;
                    err_val   = ERR_TIMEOUT;
                end
            end
            S_RX: begin
                if (tmr == '0) begin
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                state_nxt = S_END;
                err_set   = 1'b1;
                if (SI) begin
                    err_val = ERR_STOP;
                end else if (RXDATA != EXP_WORD) begin
                    err_val = ERR_PAYLOAD;
                end else begin
                    err_val = ERR_OK;
                end
            end
            S_END: begin
                state_nxt = retry_now ? S_CRST : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shared down-counter: loaded on entry to a timed state, counts to 0.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            tmr <= '0;
        end else if (state_nxt != state) begin
            case (state_nxt)
                S_CRST:  tmr <= TW'(RST_CYC - 1);
                S_WAIT:  tmr <= TW'(TIMEOUT - 1);
                S_RX:    tmr <= TW'(15);
                default: tmr <= '0;
            endcase
        end else if (tmr != '0) begin
            tmr <= tmr - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ERR      <= ERR_OK;
            PASS     <= 1'b0;
            CTRL1_B7 <= 1'b0;
        end else if (start_acc) begin
            ERR  <= ERR_OK;
            PASS <= 1'b0;
        end else if (err_set) begin
            // Result lands on the edge into END so it is valid with DONE.
            ERR  <= err_val;
            PASS <= (err_val == ERR_OK);
            if (err_val == ERR_OK) begin
                CTRL1_B7 <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            RXDATA <= '0;
        end else if (state == S_RX) begin
            RXDATA <= {SI, RXDATA[15:1]};
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        CART_RSTn = 1'b1;
        ADDR      = 8'h00;
        ADDR_OE   = 1'b0;
        BUSY      = 1'b1;
        DONE      = 1'b0;
        case (state)
            S_IDLE: BUSY = 1'b0;
            S_CRST: CART_RSTn = 1'b0;
            S_ACK: begin
                ADDR    = 8'h5A;
                ADDR_OE = 1'b1;
            end
            S_NAK: begin
                ADDR    = 8'hA5;
                ADDR_OE = 1'b1;
            end
            S_END: begin
                DONE = !retry_now;
                BUSY = retry_now;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bandai_unlock_host.sv
module tb_bandai_unlock_host;

    localparam int RST_CYC   = 8;
    localparam int TIMEOUT   = 64;
    localparam int LAT_FRAME = RST_CYC + 23;
    localparam int LAT_TMO   = RST_CYC + TIMEOUT + 5;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        START;
    logic        CART_RSTn;
    logic [7:0]  ADDR;
    logic        ADDR_OE;
    logic        SI;
    logic        BUSY;
    logic        DONE;
    logic        PASS;
    logic [1:0]  ERR;
    logic [15:0] RXDATA;
    logic        CTRL1_B7;

    int checks = 0;
    int errors = 0;

    bandai_unlock_host #(
        .RST_CYC  (RST_CYC),
        .TIMEOUT  (TIMEOUT),
        .EXP_WORD (16'h28A0),
        .MAX_RETRY(3)
    ) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .START    (START),
        .CART_RSTn(CART_RSTn),
        .ADDR     (ADDR),
        .ADDR_OE  (ADDR_OE),
        .SI       (SI),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .PASS     (PASS),
        .ERR      (ERR),
        .RXDATA   (RXDATA),
        .CTRL1_B7 (CTRL1_B7)
    );

    always #5 CLK = ~CLK;

    // ---------------- cartridge model ----------------
    logic        mdl_stuck   = 1'b0;
    logic [15:0] mdl_payload = 16'h28A0;
    logic        mdl_stop    = 1'b0;
    logic [15:0] mdl_bad     = 16'h28A1;
    int          mdl_bad_n   = 0;
    int          mdl_base    = 0;
    int          mdl_loads   = 0;

    initial begin : cart_model
        logic [17:0] fr;
        logic [15:0] p;
        logic        saw;
        fr = '1;
        SI = 1'b1;
        forever begin
            @(negedge CLK);
            saw = RSTn && ADDR_OE && (ADDR == 8'hA5) && !mdl_stuck;
            @(posedge CLK);
            if (saw) begin
                p = mdl_payload;
                if ((mdl_loads - mdl_base) < mdl_bad_n) p = mdl_bad;
                mdl_loads = mdl_loads + 1;
                SI <= 1'b0;
                fr = {1'b1, mdl_stop, p};
            end else begin
                SI <= fr[0];
                fr = {1'b1, fr[17:1]};
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [1:0]  err;
        logic        pass;
        logic [15:0] rx;
        logic        ctrl;
    } exp_t;

    exp_t sbq[$];

    typedef struct {
        logic        stuck;
        logic [15:0] payload;
        logic        stop;
        logic [1:0]  e_err;
        logic        e_pass;
        logic [15:0] e_rx;
        logic        e_ctrl;
        int          e_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name, input string why);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, why);
    endtask

    task automatic sb_push(input logic [1:0] e, input logic p, input logic [15:0] r, input logic c);
        exp_t x;
        x.err = e; x.pass = p; x.rx = r; x.ctrl = c;
        sbq.push_back(x);
    endtask

    task automatic sb_check(input string tag);
        exp_t x;
        if (sbq.size() == 0) begin
            fail_msg(tag, "scoreboard empty at DONE");
            return;
        end
        x = sbq.pop_front();
        chk({tag, ".err"},  {30'd0, ERR},      {30'd0, x.err});
        chk({tag, ".pass"}, {31'd0, PASS},     {31'd0, x.pass});
        chk({tag, ".rx"},   {16'd0, RXDATA},   {16'd0, x.rx});
        chk({tag, ".ctrl"}, {31'd0, CTRL1_B7}, {31'd0, x.ctrl});
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        bit got;
        string tag;
        tag = $sformatf("vec%0d", idx);
        mdl_stuck = v.stuck; mdl_payload = v.payload; mdl_stop = v.stop;
        sb_push(v.e_err, v.e_pass, v.e_rx, v.e_ctrl);
        pulse_start();
        lat = 1; got = 0;
        while (!got && lat < 600) begin
            @(negedge CLK);
            lat++;
            if (DONE) got = 1;
        end
        if (!got) begin
            fail_msg(tag, "no DONE within cycle budget");
            void'(sbq.pop_front());
            return;
        end
        sb_check(tag);
`ifdef BANDAI_RETRY_EN
        if (v.e_err == 2'b00) chk({tag, ".lat"}, lat, v.e_lat);
`else
        chk({tag, ".lat"}, lat, v.e_lat);
`endif
    endtask

    function automatic vec_t mk(input logic st, input logic [15:0] pl, input logic sp,
                                input logic [1:0] e, input logic p, input logic [15:0] r,
                                input logic c, input int l);
        vec_t v;
        v.stuck = st; v.payload = pl; v.stop = sp; v.e_err = e;
        v.e_pass = p; v.e_rx = r; v.e_ctrl = c; v.e_lat = l;
        return v;
    endfunction

    initial begin : guard
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    initial begin : main
        int lat, crst_lo, first_lo, oe_cnt, bad_addr, busy_seen, pulses, dones;
        logic [8:0] a_ack, a_nak;
        logic prev_crst;
        bit got;

        //           stuck payload   stop err    pass rx        ctrl lat
        vecs[0] = mk(1'b1, 16'h28A0, 1'b0, 2'b01, 1'b0, 16'h0000, 1'b0, LAT_TMO);
        vecs[1] = mk(1'b0, 16'h28A1, 1'b0, 2'b10, 1'b0, 16'h28A1, 1'b0, LAT_FRAME);
        vecs[2] = mk(1'b0, 16'h28A0, 1'b1, 2'b11, 1'b0, 16'h28A0, 1'b0, LAT_FRAME);
        vecs[3] = mk(1'b0, 16'h28A0, 1'b0, 2'b00, 1'b1, 16'h28A0, 1'b1, LAT_FRAME);
        vecs[4] = mk(1'b0, 16'h0000, 1'b0, 2'b10, 1'b0, 16'h0000, 1'b1, LAT_FRAME);
        vecs[5] = mk(1'b1, 16'h28A0, 1'b0, 2'b01, 1'b0, 16'h0000, 1'b1, LAT_TMO);
        vecs[6] = mk(1'b0, 16'h28A1, 1'b1, 2'b11, 1'b0, 16'h28A1, 1'b1, LAT_FRAME);
        vecs[7] = mk(1'b0, 16'hD75F, 1'b0, 2'b10, 1'b0, 16'hD75F, 1'b1, LAT_FRAME);

        RSTn = 1'b0;
        START = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_values",
            {CART_RSTn, ADDR, ADDR_OE, BUSY, DONE, PASS, ERR, RXDATA, CTRL1_B7},
            32'h8000_0000);
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);
        chk("idle_after_reset", {31'd0, BUSY}, 32'd0);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reset during RX bit 7 clears everything, including CTRL1_B7.
        mdl_stuck = 1'b0; mdl_payload = 16'h28A0; mdl_stop = 1'b0;
        pulse_start();
        lat = 1;
        while (lat < 21) begin
            @(negedge CLK);
            lat++;
        end
        chk("rst_mid.busy_before", {31'd0, BUSY}, 32'd1);
        RSTn = 1'b0;
        #1;
        chk("rst_mid.values",
            {CART_RSTn, ADDR, ADDR_OE, BUSY, DONE, PASS, ERR, RXDATA, CTRL1_B7},
            32'h8000_0000);
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        repeat (25) @(negedge CLK);

        // Detailed nominal sequence, with START pulses while busy and in END.
        sb_push(2'b00, 1'b1, 16'h28A0, 1'b1);
        pulse_start();
        lat = 1; crst_lo = 0; first_lo = 0; oe_cnt = 0; bad_addr = 0;
        a_ack = '0; a_nak = '0; got = 0;
        while (!got && lat < 600) begin
            @(negedge CLK);
            lat++;
            if (!CART_RSTn) begin
                crst_lo++;
                if (first_lo == 0) first_lo = lat;
            end
            if (ADDR_OE) oe_cnt++;
            if (!ADDR_OE && ADDR != 8'h00) bad_addr++;
            if (lat == 11) a_ack = {ADDR_OE, ADDR};
            if (lat == 12) a_nak = {ADDR_OE, ADDR};
            START = (lat == 15);
            if (DONE) got = 1;
        end
        if (!got) begin
            fail_msg("nominal", "no DONE within cycle budget");
        end else begin
            START = 1'b1;
            sb_check("nominal");
            chk("nominal.lat", lat, LAT_FRAME);
            chk("nominal.crst_len", crst_lo, RST_CYC);
            chk("nominal.crst_first", first_lo, 2);
            chk("nominal.addr_ack", {23'd0, a_ack}, {23'd0, 9'h15A});
            chk("nominal.addr_nak", {23'd0, a_nak}, {23'd0, 9'h1A5});
            chk("nominal.oe_cycles", oe_cnt, 2);
            chk("nominal.addr_idle", bad_addr, 0);
            @(posedge CLK);
            #1 START = 1'b0;
            busy_seen = 0;
            repeat (4) begin
                @(negedge CLK);
                if (BUSY || !CART_RSTn) busy_seen++;
            end
            chk("start_in_end_ignored", busy_seen, 0);
        end

`ifdef BANDAI_RETRY_EN
        for (int k = 0; k < 2; k++) begin
            mdl_stuck = 1'b0; mdl_payload = 16'h28A0; mdl_stop = 1'b0;
            mdl_bad_n = (k == 0) ? 2 : 99;
            mdl_base = mdl_loads;
            if (k == 0) sb_push(2'b00, 1'b1, 16'h28A0, 1'b1);
            else        sb_push(2'b10, 1'b0, 16'h28A1, 1'b1);
            pulse_start();
            lat = 1; pulses = 0; dones = 0; prev_crst = 1'b1; got = 0;
            while (!got && lat < 2000) begin
                @(negedge CLK);
                lat++;
                if (prev_crst && !CART_RSTn) pulses++;
                prev_crst = CART_RSTn;
                if (DONE) begin
                    dones++;
                    got = 1;
                end
            end
            if (!got) begin
                fail_msg($sformatf("retry%0d", k), "no DONE within cycle budget");
                void'(sbq.pop_front());
            end else begin
                sb_check($sformatf("retry%0d", k));
                chk($sformatf("retry%0d.pulses", k), pulses, (k == 0) ? 3 : 4);
                chk($sformatf("retry%0d.dones", k), dones, 1);
            end
            @(negedge CLK);
        end
        mdl_bad_n = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
